// File: rtl/ber_monitor_if.sv
// Port bundle for ber_monitor: reference/rx sample streams, measurement control and results.
// The master drives stimulus and control; the slave (the monitor) reports status and counts.
interface ber_monitor_if #(
  parameter int WIN_WIDTH = 24,
  parameter int CNT_WIDTH = 32
);
  typedef logic signed [11:0] sample_t;

  logic [3:0]           ref_sym;
  logic                 ref_valid;
  sample_t              rx_I;
  sample_t              rx_Q;
  logic                 rx_valid;
  logic                 start;
  logic [WIN_WIDTH-1:0] window_len;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] err_bits;
  logic [CNT_WIDTH-1:0] total_bits;
  logic                 fifo_ovf;
  logic                 fifo_unf;

  modport master (
    output ref_sym, ref_valid, rx_I, rx_Q, rx_valid, start, window_len,
    input  busy, done, err_bits, total_bits, fifo_ovf, fifo_unf
  );

  modport slave (
    input  ref_sym, ref_valid, rx_I, rx_Q, rx_valid, start, window_len,
    output busy, done, err_bits, total_bits, fifo_ovf, fifo_unf
  );
endinterface

// File: rtl/ber_monitor.sv
// 16-QAM hard-decision BER monitor: slices rx I/Q, compares with FIFO-aligned reference symbols,
// and accumulates saturating bit-error / bit counts over a programmed window (2-stage pipeline).
module ber_monitor #(
  parameter logic signed [11:0] SLICE_THR  = 12'sd1024,
  parameter int                 FIFO_DEPTH = 16,
  parameter int                 WIN_WIDTH  = 24,
  parameter int                 CNT_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ber_monitor_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [11:0] NEG_THR = -SLICE_THR;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [3:0]           mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, push_ok, pop_ok;
  logic [3:0]           head, dec;
  logic                 accept, start_ok;
  logic                 drain_cnt;
  logic [WIN_WIDTH-1:0] win_len_r, acc_cnt;
  logic                 s1_vld;
  logic [3:0]           s1_x;
  logic [2:0]           pc;
  logic [CNT_WIDTH-1:0] err_r, tot_r;
  logic [CNT_WIDTH:0]   err_sum, tot_sum;
  logic                 ovf_r, unf_r;

  function automatic logic [1:0] slice(input logic signed [11:0] x);
    if (x < NEG_THR)        return 2'b00;
    else if (x < 12'sd0)    return 2'b01;
    else if (x < SLICE_THR) return 2'b11;
    else                    return 2'b10;
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
  assign pop_ok  = bus.rx_valid && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = bus.ref_valid && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign dec     = {slice(bus.rx_I), slice(bus.rx_Q)};

  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);
  assign accept   = pop_ok && (state_q == RUN) && (acc_cnt < win_len_r);

  assign pc      = {2'b00, s1_x[0]} + {2'b00, s1_x[1]} + {2'b00, s1_x[2]} + {2'b00, s1_x[3]};
  assign err_sum = {1'b0, err_r} + {{(CNT_WIDTH-2){1'b0}}, pc};
  assign tot_sum = {1'b0, tot_r} + (CNT_WIDTH+1)'(4);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = (bus.window_len == '0) ? DONE : RUN;
      RUN:        if (accept && (acc_cnt + WIN_WIDTH'(1) == win_len_r)) state_d = DRAIN;
      DRAIN:      if (drain_cnt) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= bus.ref_sym;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      drain_cnt <= 1'b0;
      win_len_r <= '0;
      acc_cnt   <= '0;
      s1_vld    <= 1'b0;
      s1_x      <= '0;
      err_r     <= '0;
      tot_r     <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      ovf_r     <= (ovf_r & ~start_ok) | (bus.ref_valid & full & ~pop_ok);
      unf_r     <= (unf_r & ~start_ok) | (bus.rx_valid & empty);
      drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
      if (start_ok) begin
        win_len_r <= bus.window_len;
        acc_cnt   <= '0;
        s1_vld    <= 1'b0;
        err_r     <= '0;
        tot_r     <= '0;
      end else begin
        s1_vld <= accept;
        s1_x   <= dec ^ head;
        if (accept) acc_cnt <= acc_cnt + 1'b1;
        // Counters stick at all-ones rather than wrapping.
        if (s1_vld) begin
          err_r <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
          tot_r <= tot_sum[CNT_WIDTH] ? '1 : tot_sum[CNT_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done       = (state_q == DONE);
  assign bus.err_bits   = err_r;
  assign bus.total_bits = tot_r;
  assign bus.fifo_ovf   = ovf_r;
  assign bus.fifo_unf   = unf_r;
endmodule

// File: tb/tb_ber_monitor.sv
// Directed bench for ber_monitor; a 6-bit-counter copy shares the stimulus to exercise saturation.
module tb_ber_monitor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ber_monitor_if #(.WIN_WIDTH(24), .CNT_WIDTH(32)) bus ();
  ber_monitor_if #(.WIN_WIDTH(24), .CNT_WIDTH(6))  bus6 ();

  assign bus6.ref_sym    = bus.ref_sym;
  assign bus6.ref_valid  = bus.ref_valid;
  assign bus6.rx_I       = bus.rx_I;
  assign bus6.rx_Q       = bus.rx_Q;
  assign bus6.rx_valid   = bus.rx_valid;
  assign bus6.start      = bus.start;
  assign bus6.window_len = bus.window_len;

  ber_monitor #(.CNT_WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  ber_monitor #(.CNT_WIDTH(6))  dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string tag;
    int    err;
    int    tot;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat6(input int x);
    return (x > 63) ? 63 : x;
  endfunction

  function automatic logic signed [11:0] lvl(input logic [1:0] b);
    case (b)
      2'b00:   return -12'sd1536;
      2'b01:   return -12'sd512;
      2'b11:   return 12'sd512;
      default: return 12'sd1536;
    endcase
  endfunction

  task automatic cyc(input logic rv, input logic [3:0] rs, input logic xv,
                     input logic signed [11:0] xi, input logic signed [11:0] xq);
    @(posedge clk); #1;
    bus.ref_valid = rv;
    bus.ref_sym   = rs;
    bus.rx_valid  = xv;
    bus.rx_I      = xi;
    bus.rx_Q      = xq;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 12'sd0, 12'sd0);
  endtask

  task automatic start_win(input int wl);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.window_len = wl[23:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // mode 0: exact points; mode 1: I=+1100 against ref I bits 11; mode 2: inverted symbols
  task automatic stream(input string tag, input int n, input int mode);
    logic [3:0] refs[$];
    logic [3:0] txd[$];
    logic [3:0] r, d;
    logic signed [11:0] xi, xq;
    int e = 0;
    for (int i = 0; i < n; i++) begin
      r = 4'($urandom_range(0, 15));
      if (mode == 1) r[3:2] = 2'b11;
      d = (mode == 0) ? r : (mode == 1) ? {2'b10, r[1:0]} : ~r;
      refs.push_back(r);
      txd.push_back(d);
      e += $countones(d ^ r);
    end
    sb.push_back('{tag, e, 4 * n});
    for (int k = 0; k < n + 2; k++) begin
      xi = 12'sd0;
      xq = 12'sd0;
      if (k >= 2) begin
        xi = (mode == 1) ? 12'sd1100 : lvl(txd[k-2][3:2]);
        xq = lvl(txd[k-2][1:0]);
      end
      cyc(k < n, (k < n) ? refs[k] : 4'h0, k >= 2, xi, xq);
    end
    idle();
  endtask

  task automatic finish_win(input int lat_exp);
    exp_t e;
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.done !== 1'b1 && cnt < 500);
    e = sb.pop_front();
    chk({e.tag, "_done"}, 32'(bus.done), 32'd1);
    chk({e.tag, "_latency"}, 32'(cnt), 32'(lat_exp));
    chk({e.tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({e.tag, "_err"}, bus.err_bits, 32'(e.err));
    chk({e.tag, "_total"}, bus.total_bits, 32'(e.tot));
    chk({e.tag, "_err6"}, 32'(bus6.err_bits), 32'(sat6(e.err)));
    chk({e.tag, "_total6"}, 32'(bus6.total_bits), 32'(sat6(e.tot)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r0, r1;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.window_len = '0;
    bus.ref_valid = 1'b0;
    bus.ref_sym = 4'h0;
    bus.rx_valid = 1'b0;
    bus.rx_I = 12'sd0;
    bus.rx_Q = 12'sd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", bus.err_bits, 32'd0);
    chk("rst_total", bus.total_bits, 32'd0);
    chk("rst_ovf", 32'(bus.fifo_ovf), 32'd0);
    chk("rst_unf", 32'(bus.fifo_unf), 32'd0);

    start_win(100);
    @(negedge clk);
    chk("start_busy", 32'(bus.busy), 32'd1);
    stream("clean100", 100, 0);
    finish_win(3);
    chk("clean_ovf", 32'(bus.fifo_ovf), 32'd0);
    chk("clean_unf", 32'(bus.fifo_unf), 32'd0);

    start_win(10);
    stream("single_axis", 10, 1);
    finish_win(3);

    start_win(8);
    stream("max_err8", 8, 2);
    finish_win(3);

    start_win(20);
    stream("saturate20", 20, 2);
    finish_win(3);

    start_win(0);
    @(negedge clk);
    chk("win0_done", 32'(bus.done), 32'd1);
    chk("win0_busy", 32'(bus.busy), 32'd0);
    chk("win0_err", bus.err_bits, 32'd0);
    chk("win0_total", bus.total_bits, 32'd0);

    // A second start mid-window must not shorten or clear the measurement.
    start_win(6);
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i * 3), 1'b0, 12'sd0, 12'sd0);
    for (int i = 0; i < 3; i++) begin
      r0 = 4'(i * 3);
      cyc(1'b0, 4'h0, 1'b1, lvl(r0[3:2]), lvl(r0[1:0]));
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.start = 1'b1;
    bus.window_len = 24'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 3; i < 6; i++) begin
      r0 = 4'(i * 3);
      cyc(1'b0, 4'h0, 1'b1, lvl(r0[3:2]), lvl(r0[1:0]));
    end
    sb.push_back('{"restart_ignored", 0, 24});
    idle();
    finish_win(3);

    cyc(1'b0, 4'h0, 1'b1, 12'sd0, 12'sd0);
    idle();
    @(negedge clk);
    chk("unf_set", 32'(bus.fifo_unf), 32'd1);
    chk("unf_err", bus.err_bits, 32'd0);
    chk("unf_total", bus.total_bits, 32'd24);

    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 1'b0, 12'sd0, 12'sd0);
    idle();
    @(negedge clk);
    chk("full16_ovf", 32'(bus.fifo_ovf), 32'd0);
    cyc(1'b1, 4'hF, 1'b0, 12'sd0, 12'sd0);
    idle();
    @(negedge clk);
    chk("push17_ovf", 32'(bus.fifo_ovf), 32'd1);

    start_win(0);
    @(negedge clk);
    chk("rearm_ovf_clr", 32'(bus.fifo_ovf), 32'd0);
    chk("rearm_unf_clr", 32'(bus.fifo_unf), 32'd0);
    cyc(1'b1, 4'h5, 1'b1, 12'sd0, 12'sd0);
    idle();
    @(negedge clk);
    chk("full_pushpop_ovf", 32'(bus.fifo_ovf), 32'd0);
    chk("full_pushpop_unf", 32'(bus.fifo_unf), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'h0, 1'b1, 12'sd0, 12'sd0);
    idle();
    @(negedge clk);
    chk("drain16_unf", 32'(bus.fifo_unf), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 12'sd0, 12'sd0);
    idle();
    @(negedge clk);
    chk("drain17_unf", 32'(bus.fifo_unf), 32'd1);

    start_win(10);
    r0 = 4'h3;
    r1 = 4'hC;
    cyc(1'b1, r0, 1'b0, 12'sd0, 12'sd0);
    cyc(1'b1, r1, 1'b0, 12'sd0, 12'sd0);
    cyc(1'b0, 4'h0, 1'b1, lvl(~r0[3:2]), lvl(~r0[1:0]));
    cyc(1'b0, 4'h0, 1'b1, lvl(~r1[3:2]), lvl(~r1[1:0]));
    idle();
    idle();
    @(negedge clk);
    chk("midwin_err", bus.err_bits, 32'd8);
    chk("midwin_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_err", bus.err_bits, 32'd0);
    chk("midrst_total", bus.total_bits, 32'd0);
    chk("midrst_ovf", 32'(bus.fifo_ovf), 32'd0);
    chk("midrst_unf", 32'(bus.fifo_unf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
